// File: rtl/mu0_ctrl_fsm_gen2_if.sv
// Control/datapath signal bundle for the MU0 gen2 control unit.
// The icount member exists only when MU0_ICOUNT_EN is defined.
interface mu0_ctrl_fsm_gen2_if #(
  parameter int OPW = 4
`ifdef MU0_ICOUNT_EN
  , parameter int ICNT_W = 16
`endif
);
  logic [OPW-1:0] opcode;
  logic           accz;
  logic           acc15;
  logic           mem_ready;
  logic           run;
  logic           asel;
  logic           bsel;
  logic           accce;
  logic           pcce;
  logic           irce;
  logic           accoe;
  logic [1:0]     alufs;
  logic           memrq;
  logic           rnw;
  logic           halted;
  logic           err;
`ifdef MU0_ICOUNT_EN
  logic [ICNT_W-1:0] icount;

  modport master (
    input  opcode, accz, acc15, mem_ready, run,
    output asel, bsel, accce, pcce, irce, accoe, alufs, memrq, rnw, halted, err, icount
  );
  modport slave (
    output opcode, accz, acc15, mem_ready, run,
    input  asel, bsel, accce, pcce, irce, accoe, alufs, memrq, rnw, halted, err, icount
  );
`else
  modport master (
    input  opcode, accz, acc15, mem_ready, run,
    output asel, bsel, accce, pcce, irce, accoe, alufs, memrq, rnw, halted, err
  );
  modport slave (
    output opcode, accz, acc15, mem_ready, run,
    input  asel, bsel, accce, pcce, irce, accoe, alufs, memrq, rnw, halted, err
  );
`endif
endinterface

// File: rtl/mu0_ctrl_fsm_gen2.sv
// MU0 gen2 control unit: fetch/execute sequencer with memory wait handshake, timeout,
// resumable HALT and sticky ERR. Define MU0_ICOUNT_EN to add the retired-instruction counter.
module mu0_ctrl_fsm_gen2 #(
  parameter int OPW      = 4,
  parameter int WAIT_TMO = 16
`ifdef MU0_ICOUNT_EN
  , parameter int ICNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  mu0_ctrl_fsm_gen2_if.master  bus
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [7:0] WCNT_LAST = 8'(WAIT_TMO - 1);

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;

  logic       asel_c, bsel_c, accce_c, pcce_c, irce_c, accoe_c;
  logic [1:0] alufs_c;
  logic       memrq_c, rnw_c, halted_c, err_c;
  logic [2:0] op;
  logic       illegal;
  logic       taken;

  always_comb begin
    op      = bus.opcode[2:0];
    illegal = (bus.opcode >> 3) != '0;

    asel_c   = 1'b0;
    bsel_c   = 1'b0;
    accce_c  = 1'b0;
    pcce_c   = 1'b0;
    irce_c   = 1'b0;
    accoe_c  = 1'b0;
    alufs_c  = 2'b00;
    memrq_c  = 1'b0;
    rnw_c    = 1'b1;
    taken    = 1'b0;
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    halted_c = (state_q == S_HALT);
    err_c    = (state_q == S_ERR);

    case (state_q)
      S_FETCH: begin
        alufs_c = 2'b01;
        memrq_c = 1'b1;
        pcce_c  = bus.mem_ready;
        irce_c  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (illegal) begin
          state_d = S_ERR;
        end else begin
          case (op)
            3'd0, 3'd2, 3'd3: begin
              asel_c  = 1'b1;
              bsel_c  = 1'b1;
              memrq_c = 1'b1;
              accce_c = bus.mem_ready;
              alufs_c = (op == 3'd2) ? 2'b10 : (op == 3'd3) ? 2'b11 : 2'b00;
              if (bus.mem_ready) state_d = S_FETCH;
            end
            3'd1: begin
              asel_c  = 1'b1;
              accoe_c = 1'b1;
              rnw_c   = 1'b0;
              memrq_c = 1'b1;
              if (bus.mem_ready) state_d = S_FETCH;
            end
            3'd4, 3'd5, 3'd6: begin
              // Jumps fetch the next instruction themselves, so EXEC is re-entered.
              taken   = (op == 3'd4) || (op == 3'd5 && !bus.acc15) || (op == 3'd6 && !bus.accz);
              asel_c  = taken;
              alufs_c = 2'b01;
              memrq_c = 1'b1;
              pcce_c  = bus.mem_ready;
              irce_c  = bus.mem_ready;
            end
            default: state_d = S_HALT;
          endcase
        end
      end
      S_HALT: begin
        if (bus.run) state_d = S_FETCH;
      end
      default: ;
    endcase

    if (memrq_c) begin
      if (bus.mem_ready) begin
        wcnt_d = '0;
      end else begin
        wcnt_d = wcnt_q + 8'd1;
        if (wcnt_q == WCNT_LAST) state_d = S_ERR;
      end
    end

    if (reset) begin
      asel_c   = 1'b0;
      bsel_c   = 1'b0;
      accce_c  = 1'b1;
      pcce_c   = 1'b1;
      irce_c   = 1'b1;
      accoe_c  = 1'b0;
      alufs_c  = 2'b00;
      memrq_c  = 1'b0;
      rnw_c    = 1'b1;
      halted_c = 1'b0;
      err_c    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bus.asel   = asel_c;
  assign bus.bsel   = bsel_c;
  assign bus.accce  = accce_c;
  assign bus.pcce   = pcce_c;
  assign bus.irce   = irce_c;
  assign bus.accoe  = accoe_c;
  assign bus.alufs  = alufs_c;
  assign bus.memrq  = memrq_c;
  assign bus.rnw    = rnw_c;
  assign bus.halted = halted_c;
  assign bus.err    = err_c;

`ifdef MU0_ICOUNT_EN
  logic [ICNT_W-1:0] icount_q, icount_d;
  logic              retire;

  always_comb begin
    retire   = (state_q == S_EXEC) &&
               ((memrq_c && bus.mem_ready) || (!illegal && op == 3'd7));
    icount_d = retire ? icount_q + ICNT_W'(1) : icount_q;
  end

  always_ff @(posedge clk) begin
    if (reset) icount_q <= '0;
    else       icount_q <= icount_d;
  end

  assign bus.icount = icount_q;
`endif

endmodule
